// File: rtl/cplx_mul_pkg.sv
// Shared types and width/offset helpers for the sequential complex multiplier.
package cplx_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RES  = 2'd2
   } state_t;

   localparam int STEP_W = 2;

   // Field indices: op_data {a_re, a_im, b_re, b_im}, res_data {p_re, p_im}, MSB field first
   localparam int F_A_RE = 0;
   localparam int F_A_IM = 1;
   localparam int F_B_RE = 2;
   localparam int F_B_IM = 3;
   localparam int F_P_RE = 0;
   localparam int F_P_IM = 1;

   function automatic int prod_w(input int dw);
      return 2 * dw;
   endfunction

   function automatic int acc_w(input int dw);
      return 2 * dw + 1;
   endfunction

   function automatic int res_w(input int dw);
      return 2 * dw + 2;
   endfunction

   function automatic int op_lsb(input int dw, input int idx);
      return (3 - idx) * dw;
   endfunction

   function automatic int res_lsb(input int dw, input int idx);
      return (1 - idx) * res_w(dw);
   endfunction

endpackage

// File: rtl/cplx_mul_seq_if.sv
// Operand and result valid/ready channels of the complex multiplier.
interface cplx_mul_seq_if #(
   parameter int DWIDTH = 8
);
   logic                  op_val;
   logic                  op_rdy;
   logic [4*DWIDTH-1:0]   op_data;
   logic                  res_val;
   logic                  res_rdy;
   logic [4*DWIDTH+3:0]   res_data;

   modport master (
      output op_val, op_data, res_rdy,
      input  op_rdy, res_val, res_data
   );

   modport slave (
      input  op_val, op_data, res_rdy,
      output op_rdy, res_val, res_data
   );
endinterface

// File: rtl/cplx_mul_mac.sv
// One signed multiplier feeding a clearable add/subtract accumulator.
module cplx_mul_mac
   import cplx_mul_pkg::*;
#(
   parameter int DWIDTH = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             clr,
   input  logic                             en,
   input  logic                             sub,
   input  logic signed [DWIDTH-1:0]         x,
   input  logic signed [DWIDTH-1:0]         y,
   output logic signed [acc_w(DWIDTH)-1:0]  acc_nxt
);
   localparam int PW = prod_w(DWIDTH);
   localparam int AW = acc_w(DWIDTH);

   logic signed [PW-1:0] x_ext;
   logic signed [PW-1:0] y_ext;
   logic signed [PW-1:0] prod;
   logic signed [AW-1:0] prod_ext;
   logic signed [AW-1:0] acc_q;

   assign x_ext    = {{DWIDTH{x[DWIDTH-1]}}, x};
   assign y_ext    = {{DWIDTH{y[DWIDTH-1]}}, y};
   assign prod     = x_ext * y_ext;
   assign prod_ext = {prod[PW-1], prod};

   // acc_nxt is exported so the final step can be packed into the result in the same edge
   always_comb begin
      acc_nxt = acc_q;
      if (clr)
         acc_nxt = '0;
      else if (en)
         acc_nxt = sub ? (acc_q - prod_ext) : (acc_q + prod_ext);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc_q <= '0;
      else
         acc_q <= acc_nxt;
   end

endmodule

// File: rtl/cplx_mul_seq.sv
// Sequential signed complex multiplier, p = a*b over four multiply steps.
// CPLX_MUL_BACK2BACK_EN: accept the next operand in the same edge the result is taken.
//
// state | meaning
// IDLE  | waiting for an operand pair, op_rdy high
// MUL   | four multiply/accumulate steps, step 0..3
// RES   | result held on res_data with res_val high until res_rdy
module cplx_mul_seq
   import cplx_mul_pkg::*;
#(
   parameter int DWIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           sw_rst,
   cplx_mul_seq_if.slave  bus
);
   localparam int AW = acc_w(DWIDTH);
   localparam int RW = res_w(DWIDTH);

   localparam int A_RE_LSB = op_lsb(DWIDTH, F_A_RE);
   localparam int A_IM_LSB = op_lsb(DWIDTH, F_A_IM);
   localparam int B_RE_LSB = op_lsb(DWIDTH, F_B_RE);
   localparam int B_IM_LSB = op_lsb(DWIDTH, F_B_IM);
   localparam int P_RE_LSB = res_lsb(DWIDTH, F_P_RE);
   localparam int P_IM_LSB = res_lsb(DWIDTH, F_P_IM);

   state_t                   state_q, state_d;
   logic [STEP_W-1:0]        step_q, step_d;
   logic [4*DWIDTH-1:0]      op_q;
   logic                     res_val_q, res_val_d;
   logic [2*RW-1:0]          res_data_q, res_data_d;
   logic                     rdy_q, rdy_d;
   logic                     op_rdy;
   logic                     accept;
   logic                     mac_clr;
   logic                     en_re, en_im, sub_re;
   logic signed [DWIDTH-1:0] a_re, a_im, b_re, b_im;
   logic signed [DWIDTH-1:0] mul_x, mul_y;
   logic signed [AW-1:0]     acc_re_nxt, acc_im_nxt;

   assign a_re = op_q[A_RE_LSB +: DWIDTH];
   assign a_im = op_q[A_IM_LSB +: DWIDTH];
   assign b_re = op_q[B_RE_LSB +: DWIDTH];
   assign b_im = op_q[B_IM_LSB +: DWIDTH];

   // rdy_q keeps op_rdy low while in reset even when ready is decoded from state
`ifdef CPLX_MUL_BACK2BACK_EN
   assign op_rdy = rdy_q && ((state_q == IDLE) || ((state_q == RES) && bus.res_rdy));
`else
   assign op_rdy = rdy_q;
`endif

   assign accept       = bus.op_val && op_rdy;
   assign bus.op_rdy   = op_rdy;
   assign bus.res_val  = res_val_q;
   assign bus.res_data = res_data_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         step_q     <= '0;
         op_q       <= '0;
         res_val_q  <= 1'b0;
         res_data_q <= '0;
         rdy_q      <= 1'b0;
      end else if (sw_rst) begin
         state_q    <= IDLE;
         step_q     <= '0;
         op_q       <= '0;
         res_val_q  <= 1'b0;
         res_data_q <= '0;
         rdy_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         res_val_q  <= res_val_d;
         res_data_q <= res_data_d;
         rdy_q      <= rdy_d;
         if (accept)
            op_q <= bus.op_data;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = MUL;
         MUL:     if (&step_q) state_d = RES;
         RES:     if (bus.res_rdy) state_d = accept ? MUL : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Step order: re += a_re*b_re, re -= a_im*b_im, im += a_re*b_im, im += a_im*b_re
   always_comb begin
      step_d     = (state_q == MUL) ? step_q + STEP_W'(1) : '0;
      mac_clr    = accept || sw_rst;
      en_re      = (state_q == MUL) && !step_q[1];
      en_im      = (state_q == MUL) && step_q[1];
      sub_re     = step_q[0];
      mul_x      = step_q[0] ? a_im : a_re;
      mul_y      = (step_q[0] ^ step_q[1]) ? b_im : b_re;
      res_val_d  = (state_d == RES);
      res_data_d = res_data_q;
      if ((state_q == MUL) && (&step_q)) begin
         res_data_d[P_RE_LSB +: RW] = {acc_re_nxt[AW-1], acc_re_nxt};
         res_data_d[P_IM_LSB +: RW] = {acc_im_nxt[AW-1], acc_im_nxt};
      end
`ifdef CPLX_MUL_BACK2BACK_EN
      rdy_d = 1'b1;
`else
      rdy_d = (state_d == IDLE);
`endif
   end

   cplx_mul_mac #(.DWIDTH(DWIDTH)) u_mac_re (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (mac_clr),
      .en      (en_re),
      .sub     (sub_re),
      .x       (mul_x),
      .y       (mul_y),
      .acc_nxt (acc_re_nxt)
   );

   cplx_mul_mac #(.DWIDTH(DWIDTH)) u_mac_im (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (mac_clr),
      .en      (en_im),
      .sub     (1'b0),
      .x       (mul_x),
      .y       (mul_y),
      .acc_nxt (acc_im_nxt)
   );

endmodule
